rnd_hex_ctrl: RTL
=================

// Module: rnd_hex_ctrl
// PURPOSE
//   Sequencer for the random-hex display path. Consumes the single-cycle tick strobe
//   from the clock divider and steps a Galois LFSR every UPD_TICKS ticks while running.
//   Freezes/resumes on start/stop commands and time-multiplexes the latched value onto
//   a DIGITS-wide 7-segment bank, one digit per tick. Sits between divider and hex decoder.
// PARAMETERS
//   DIGITS     4        number of hex digits shown; 4*DIGITS <= LFSR_W
//   LFSR_W     16       LFSR width; feedback mask fixed at 16'hB400 (x^16+x^14+x^13+x^11+1)
//   SEED       16'hACE1 LFSR reset/clear value; a zero SEED is replaced by 1
//   UPD_TICKS  8        ticks between value updates in RUN, >= 1
// PORTS
//   clk     in   1          system clock
//   rst     in   1          asynchronous reset, active-high
//   tick    in   1          divider strobe, one clk cycle wide
//   start   in   1          pulse: IDLE/HOLD -> RUN
//   stop    in   1          pulse: RUN -> HOLD
//   clr     in   1          pulse: return to IDLE, clear value, reload SEED
//   value   out  4*DIGITS   latched random value
//   upd     out  1          one-cycle pulse, high in the cycle value has just changed
//   anode   out  DIGITS     one-hot active-high digit select
//   nibble  out  4          value[4*idx+3 : 4*idx] for current digit idx
//   running out  1          high in RUN
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, lfsr=SEED, value=0, tick_cnt=0, idx=0,
//     anode=1 (digit 0), nibble=0, upd=0, running=0.
//   States: IDLE, RUN, HOLD (2-bit register, all transitions on posedge clk).
//   Priority per cycle: clr > stop > start > tick activity.
//     clr (any state): -> IDLE, value=0, lfsr=SEED, tick_cnt=0; idx keeps scanning.
//     IDLE: start -> RUN, tick_cnt=0; stop ignored.
//     RUN: stop -> HOLD (tick_cnt frozen, no update that cycle even if due);
//          tick with tick_cnt==UPD_TICKS-1 -> lfsr=step(lfsr), value=step(lfsr)[4*DIGITS-1:0],
//          tick_cnt=0, upd=1 next cycle; other tick -> tick_cnt+1; start ignored.
//     HOLD: start -> RUN, tick_cnt=0 (full UPD_TICKS period before next update).
//   step(x) = (x>>1) ^ (x[0] ? 16'hB400 : 0); lfsr never reaches zero.
//   upd: registered, exactly one cycle per update; never asserted outside RUN.
//   Scan: every tick in any state idx = (idx==DIGITS-1) ? 0 : idx+1; anode = 1<<idx,
//     nibble = value slice of idx; both registered, updated same edge as idx.
//   Value change and scan step on the same tick: nibble reflects new value.
//   tick_cnt width $clog2(UPD_TICKS+1); wraps only via compare, never overflows.
//   rst mid-RUN: all registers to reset values immediately, no upd pulse.
//   running = (state==RUN), registered via state.
// TESTING
//   1 Reset, start, UPD_TICKS=8, 8 ticks -> one upd pulse, value=16'hE270 (step of ACE1).
//   2 Continue 8 more ticks -> value=16'h7138; count upd pulses == updates, no extras.
//   3 stop on same cycle as 8th tick -> HOLD, no upd, value unchanged; start then 8 ticks
//     -> exactly one update.
//   4 Scan: 5 ticks from reset -> anode 0001,0010,0100,1000,0001; nibble matches slices.
//   5 clr during RUN -> IDLE, value=0, running=0; start + 8 ticks -> value=16'hE270 again.
//   6 Assert rst mid-RUN between ticks -> outputs at reset values within same cycle;
//     start and stop asserted together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/rnd_hex_ctrl.sv
// -----------------------------------------------------------------------------
// rnd_hex_ctrl
//
// Sequencer for the random-hex display path. Sits between the clock divider
// (which supplies a one-cycle tick strobe) and the hex/7-segment decoder.
//
//   * A Galois LFSR (mask 16'hB400) is stepped once every UPD_TICKS ticks while
//     the sequencer is RUNning; the low 4*DIGITS bits are latched into `value`.
//   * start/stop freeze and resume updates, clr returns to IDLE and reloads SEED.
//   * Independently of the run state, each tick advances a digit scan that
//     drives a one-hot anode select and the matching nibble of `value`.
//
// Ports
//   clk     in   1          system clock
//   rst     in   1          asynchronous reset, active-high
//   tick    in   1          divider strobe, one clk cycle wide
//   start   in   1          pulse: IDLE/HOLD -> RUN
//   stop    in   1          pulse: RUN -> HOLD
//   clr     in   1          pulse: back to IDLE, value cleared, LFSR reloaded
//   value   out  4*DIGITS   latched random value
//   upd     out  1          high for one cycle right after value changed
//   anode   out  DIGITS     one-hot active-high digit select
//   nibble  out  4          nibble of value for the selected digit
//   running out  1          high while in RUN
// -----------------------------------------------------------------------------
module rnd_hex_ctrl #(
  parameter int                DIGITS    = 4,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                UPD_TICKS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   value,
  output logic                  upd,
  output logic [DIGITS-1:0]     anode,
  output logic [3:0]            nibble,
  output logic                  running
);

  localparam int VAL_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(UPD_TICKS + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [LFSR_W-1:0] FB_MASK   = LFSR_W'(16'hB400);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(UPD_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Galois right-shift step: x^16+x^14+x^13+x^11+1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
    return (x >> 1) ^ (x[0] ? FB_MASK : '0);
  endfunction

  state_t             state, state_nx;
  logic [LFSR_W-1:0]  lfsr, lfsr_nx;
  logic [VAL_W-1:0]   value_nx;
  logic [CNT_W-1:0]   tick_cnt, cnt_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic               upd_nx;

  // Command decode. clr outranks stop, stop outranks start, and a start in
  // RUN or a stop outside RUN is a no-op. A stop in IDLE/HOLD still masks a
  // simultaneous start, so start+stop together never leaves IDLE.
  always_comb begin
    state_nx = state;
    lfsr_nx  = lfsr;
    value_nx = value;
    cnt_nx   = tick_cnt;
    upd_nx   = 1'b0;
    if (clr) begin
      state_nx = S_IDLE;
      value_nx = '0;
      lfsr_nx  = SEED_EFF;
      cnt_nx   = '0;
    end else if (stop) begin
      // Counter frozen; an update due on this same tick is dropped.
      if (state == S_RUN) state_nx = S_HOLD;
    end else if (start && (state != S_RUN)) begin
      // Restart the period so a full UPD_TICKS elapses before the next update.
      state_nx = S_RUN;
      cnt_nx   = '0;
    end else if (tick && (state == S_RUN)) begin
      if (tick_cnt == CNT_LAST) begin
        lfsr_nx  = lfsr_step(lfsr);
        value_nx = lfsr_nx[VAL_W-1:0];
        cnt_nx   = '0;
        upd_nx   = 1'b1;
      end else begin
        cnt_nx   = tick_cnt + CNT_W'(1);
      end
    end
  end

  // Scan pointer wraps explicitly so DIGITS need not be a power of two.
  always_comb begin
    idx_nx = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      lfsr     <= SEED_EFF;
      value    <= '0;
      tick_cnt <= '0;
      idx      <= '0;
      anode    <= DIGITS'(1);
      nibble   <= 4'd0;
      upd      <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_nx;
      lfsr     <= lfsr_nx;
      value    <= value_nx;
      tick_cnt <= cnt_nx;
      upd      <= upd_nx;
      running  <= (state_nx == S_RUN);
      if (tick) begin
        // Slice the post-edge value so a same-tick update shows immediately.
        idx    <= idx_nx;
        anode  <= DIGITS'(1) << idx_nx;
        nibble <= 4'(value_nx >> (4 * idx_nx));
      end
    end
  end

endmodule
